// File: rtl/input_conditioner.sv
// Three independent switch/button conditioners: a two-flop synchronizer, a
// four-state debounce FSM and registered rise/fall pulses for each channel.
module input_conditioner #(
    parameter int DB_CYCLES = 250000,
    parameter int CNT_W     = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A_IN,
    input  logic       B_IN,
    input  logic       C_IN,
    output logic       A_OUT,
    output logic       B_OUT,
    output logic       C_OUT,
    output logic       A_RISE,
    output logic       B_RISE,
    output logic       C_RISE,
    output logic       A_FALL,
    output logic       B_FALL,
    output logic       C_FALL,
    output logic [5:0] fsm_state
);

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        TO_HIGH = 2'd1,
        HIGH    = 2'd2,
        TO_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [2:0] raw;
    logic [2:0] out_vec;
    logic [2:0] rise_vec;
    logic [2:0] fall_vec;

    assign raw = {C_IN, B_IN, A_IN};

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic           meta;
        logic           sync;
        state_t         state_q;
        state_t         state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic           out_q;
        logic           out_d;
        logic           rise_q;
        logic           rise_d;
        logic           fall_q;
        logic           fall_d;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                meta    <= 1'b0;
                sync    <= 1'b0;
                state_q <= LOW;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                meta    <= raw[i];
                sync    <= meta;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // The counter only runs in the two transitional states and is reset
        // on every exit, so it stays within 0..DB_CYCLES-1.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                LOW: begin
                    if (sync) begin
                        state_d = TO_HIGH;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                TO_HIGH: begin
                    if (!sync) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!sync) begin
                        state_d = TO_LOW;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                TO_LOW: begin
                    if (sync) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = LOW;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            endcase
            out_d = (state_d == HIGH) || (state_d == TO_LOW);
        end

        assign out_vec[i]          = out_q;
        assign rise_vec[i]         = rise_q;
        assign fall_vec[i]         = fall_q;
        assign fsm_state[2*i +: 2] = state_q;
    end

    assign A_OUT  = out_vec[0];
    assign B_OUT  = out_vec[1];
    assign C_OUT  = out_vec[2];
    assign A_RISE = rise_vec[0];
    assign B_RISE = rise_vec[1];
    assign C_RISE = rise_vec[2];
    assign A_FALL = fall_vec[0];
    assign B_FALL = fall_vec[1];
    assign C_FALL = fall_vec[2];

endmodule
